// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Scans digits 0..3, each preceded by a blanking interval to avoid ghosting.
// New display data is double-buffered: loads land in a pending buffer and are
// promoted to the active buffer only at a frame boundary, or at once while
// scanning is disabled, so a frame never mixes old and new digits.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   en         - scan enable; low blanks the display and parks at digit 0
//   load       - capture value_in/dp_in/lz_en into the pending buffer
//   value_in   - four BCD digits, [3:0] is digit 0 (least significant)
//   dp_in      - per-digit decimal point, active high
//   lz_en      - leading-zero suppression enable
//   load_ack   - one-cycle pulse when pending data becomes active
//   an_n       - digit anodes, active low, at most one low
//   bcd_out    - code to the BCD-to-7-segment decoder, 4'hF = blank
//   dp_n       - decimal point, active low
//   digit_sel  - index of the digit being scanned
module seven_seg_scan_ctrl #(
  parameter int unsigned DIGIT_CYC = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic        load_ack,
  output logic [3:0]  an_n,
  output logic [3:0]  bcd_out,
  output logic        dp_n,
  output logic [1:0]  digit_sel
);

  localparam int unsigned CntW = 20;
  localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_CYC - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

  typedef enum logic {StBlank, StShow} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            frame_end;

  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_lz_q, pend_lz_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] act_val_q, act_val_d;
  logic [3:0]  act_dp_q, act_dp_d;
  logic        act_lz_q, act_lz_d;

  logic        ack_q, ack_d;
  logic [3:0]  an_q, an_d;
  logic [3:0]  bcd_q, bcd_d;
  logic        dpn_q, dpn_d;
  logic [1:0]  selo_q, selo_d;

  logic [3:0]  zero_nib;
  logic [3:0]  cur_digit;
  logic        suppress;

  // Scan sequencer
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q + CntW'(1);
    frame_end = 1'b0;
    if (!en) begin
      state_d = StBlank;
      sel_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StShow;
            cnt_d   = '0;
          end
        end
        StShow: begin
          if (cnt_q == DigitLast) begin
            state_d   = StBlank;
            cnt_d     = '0;
            sel_d     = sel_q + 2'd1;
            frame_end = (sel_q == 2'd3);
          end
        end
      endcase
    end
  end

  // Pending/active buffers. A load on the transfer edge is folded in first so
  // it goes straight to active on that same edge.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_lz_d  = pend_lz_q;
    pend_vld_d = pend_vld_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    act_lz_d   = act_lz_q;
    ack_d      = 1'b0;
    if (load) begin
      pend_val_d = value_in;
      pend_dp_d  = dp_in;
      pend_lz_d  = lz_en;
      pend_vld_d = 1'b1;
    end
    if ((frame_end || !en) && pend_vld_d) begin
      act_val_d  = pend_val_d;
      act_dp_d   = pend_dp_d;
      act_lz_d   = pend_lz_d;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end
  end

  // Output decode from the current (pre-transfer) active buffer
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      zero_nib[k] = (act_val_q[4*k +: 4] == 4'h0);
    end
    cur_digit = act_val_q[{sel_q, 2'b00} +: 4];
    case (sel_q)
      2'd3:    suppress = zero_nib[3];
      2'd2:    suppress = zero_nib[3] & zero_nib[2];
      2'd1:    suppress = zero_nib[3] & zero_nib[2] & zero_nib[1];
      default: suppress = 1'b0;
    endcase
    suppress = suppress & act_lz_q;

    an_d   = 4'hF;
    bcd_d  = 4'hF;
    dpn_d  = 1'b1;
    selo_d = 2'd0;
    // en is looked at directly so dropping it blanks on the very next cycle
    if (en) begin
      selo_d = sel_q;
      if (state_q == StShow) begin
        an_d  = ~(4'b0001 << sel_q);
        bcd_d = suppress ? 4'hF : cur_digit;
        dpn_d = ~act_dp_q[sel_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBlank;
      sel_q      <= 2'd0;
      cnt_q      <= '0;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      pend_lz_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      act_val_q  <= 16'h0000;
      act_dp_q   <= 4'h0;
      act_lz_q   <= 1'b0;
      ack_q      <= 1'b0;
      an_q       <= 4'hF;
      bcd_q      <= 4'hF;
      dpn_q      <= 1'b1;
      selo_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_lz_q  <= pend_lz_d;
      pend_vld_q <= pend_vld_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      act_lz_q   <= act_lz_d;
      ack_q      <= ack_d;
      an_q       <= an_d;
      bcd_q      <= bcd_d;
      dpn_q      <= dpn_d;
      selo_q     <= selo_d;
    end
  end

  assign load_ack  = ack_q;
  assign an_n      = an_q;
  assign bcd_out   = bcd_q;
  assign dp_n      = dpn_q;
  assign digit_sel = selo_q;

endmodule
